// File: rtl/clkmon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clkmon_pkg
//  Description : Shared types and default parameters for the clock monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkmon_pkg;

  // Monitor FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_LOST = 2'd3
  } state_e;

  localparam int C_CNT_W_DEF       = 16;
  localparam int C_SYNC_STAGES_DEF = 2;
  localparam int C_TIMEOUT_DEF     = 64;
  localparam int C_GOOD_CNT_DEF    = 4;

endpackage : clkmon_pkg
`default_nettype wire

// File: rtl/clkmon_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clkmon_sync
//  Description : Multi-flop synchronizer for the monitored clock followed by
//                a rise/fall edge detector producing 1-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkmon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchronizer and keep the last stable value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : clkmon_sync
`default_nettype wire

// File: rtl/clkmon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : clkmon
//  Description : Measures period and high time of an asynchronous monitored
//                clock in reference-clock cycles; flags range, duty and loss
//                faults and reports a clock-ok level after consecutive good
//                periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module clkmon
  import clkmon_pkg::*;
#(
  parameter int CNT_W       = C_CNT_W_DEF,
  parameter int SYNC_STAGES = C_SYNC_STAGES_DEF,
  parameter int PERIOD_MIN  = 7,
  parameter int PERIOD_MAX  = 9,
  parameter int HIGH_MIN    = 3,
  parameter int HIGH_MAX    = 5,
  parameter int TIMEOUT     = C_TIMEOUT_DEF,
  parameter int GOOD_CNT    = C_GOOD_CNT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mon_clk_i,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] period_meas_o,
  output logic [CNT_W-1:0] high_meas_o,
  output logic             meas_vld_o,
  output logic             period_err_o,
  output logic             duty_err_o,
  output logic             clk_lost_o,
  output logic             clk_ok_o
);

  localparam int             GW     = $clog2(GOOD_CNT + 1);
  localparam logic [CNT_W-1:0] C_ONES  = '1;
  localparam logic [CNT_W-1:0] C_PMIN  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] C_PMAX  = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] C_HMIN  = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] C_HMAX  = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] C_TMO   = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    C_GOOD  = GW'(GOOD_CNT);

  logic             rise, fall;
  logic [CNT_W-1:0] pcnt_q, hcnt_q;
  logic             hfrz_q;
  logic [GW-1:0]    good_q, good_d;
  state_e           state_q;
  logic             per_bad, duty_bad;

  logic [CNT_W-1:0] period_meas_q, high_meas_q;
  logic             meas_vld_q, period_err_q, duty_err_q, clk_lost_q, clk_ok_q;

  clkmon_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (mon_clk_i),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // Period and high-time counters: restart on rise, high counter freezes on fall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      hcnt_q <= '0;
      hfrz_q <= 1'b0;
    end else if (rise) begin
      pcnt_q <= CNT_W'(1);
      hcnt_q <= CNT_W'(1);
      hfrz_q <= 1'b0;
    end else begin
      if (pcnt_q != C_ONES) pcnt_q <= pcnt_q + CNT_W'(1);
      if (fall) begin
        hfrz_q <= 1'b1;
      end else if (!hfrz_q && hcnt_q != C_ONES) begin
        hcnt_q <= hcnt_q + CNT_W'(1);
      end
    end
  end

  assign per_bad  = (pcnt_q < C_PMIN) || (pcnt_q > C_PMAX);
  assign duty_bad = (hcnt_q < C_HMIN) || (hcnt_q > C_HMAX);

  // Next good-period count for the measurement completing this cycle
  always_comb begin
    good_d = good_q;
    if (per_bad || duty_bad) begin
      good_d = '0;
    end else if (good_q != C_GOOD) begin
      good_d = good_q + GW'(1);
    end
  end

  // Monitor FSM with registered measurement, sticky-error and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      period_meas_q <= '0;
      high_meas_q   <= '0;
      meas_vld_q    <= 1'b0;
      period_err_q  <= 1'b0;
      duty_err_q    <= 1'b0;
      clk_lost_q    <= 1'b0;
      clk_ok_q      <= 1'b0;
      good_q        <= '0;
    end else begin
      meas_vld_q <= 1'b0;
      // A new error later in this block overrides the clear
      if (err_clr_i) begin
        period_err_q <= 1'b0;
        duty_err_q   <= 1'b0;
      end
      if (!en_i) begin
        state_q    <= ST_IDLE;
        clk_ok_q   <= 1'b0;
        clk_lost_q <= 1'b0;
        good_q     <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_ARM;
          ST_ARM: begin
            if (rise) state_q <= ST_MEAS;
          end
          ST_MEAS: begin
            if (rise) begin
              period_meas_q <= pcnt_q;
              high_meas_q   <= hcnt_q;
              meas_vld_q    <= 1'b1;
              if (per_bad)  period_err_q <= 1'b1;
              if (duty_bad) duty_err_q   <= 1'b1;
              good_q        <= good_d;
              clk_ok_q      <= (good_d == C_GOOD);
            end else if (pcnt_q == C_TMO) begin
              state_q    <= ST_LOST;
              clk_lost_q <= 1'b1;
              clk_ok_q   <= 1'b0;
              good_q     <= '0;
            end
          end
          ST_LOST: begin
            if (rise) begin
              state_q    <= ST_ARM;
              clk_lost_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign period_meas_o = period_meas_q;
  assign high_meas_o   = high_meas_q;
  assign meas_vld_o    = meas_vld_q;
  assign period_err_o  = period_err_q;
  assign duty_err_o    = duty_err_q;
  assign clk_lost_o    = clk_lost_q;
  assign clk_ok_o      = clk_ok_q;

endmodule : clkmon
`default_nettype wire
